// File: rtl/twilight_pkg.sv
// Shared constants and state encoding for the scaled, line-buffered sprite engine.
package twilight_pkg;

  localparam int CORDW      = 16;
  localparam int H_RES      = 640;
  localparam int SPR_WIDTH  = 32;
  localparam int SPR_HEIGHT = 20;
  localparam int SPR_SCALE  = 2;
  localparam int SPR_DATAW  = 4;
  localparam int ROM_AW     = $clog2(SPR_WIDTH * SPR_HEIGHT);

  localparam int SRC_W   = $clog2(SPR_WIDTH);
  localparam int ROW_W   = $clog2(SPR_HEIGHT);
  localparam int SUB_W   = (SPR_SCALE > 0) ? SPR_SCALE : 1;
  localparam int OFF_W   = SRC_W + SPR_SCALE;
  localparam int FCNT_W  = SRC_W + 1;
  localparam int SPR_W_PIX = SPR_WIDTH << SPR_SCALE;
  localparam int SPR_H_PIX = SPR_HEIGHT << SPR_SCALE;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAW} spr_state_t;

  function automatic logic [ROM_AW-1:0] rom_index(input logic [ROW_W-1:0] row,
                                                  input logic [SRC_W-1:0] col);
    return ROM_AW'(row * SPR_WIDTH + col);
  endfunction

endpackage

// File: rtl/spr_line_ram.sv
// One-row sprite line buffer: single write port, combinational read port.
module spr_line_ram
  import twilight_pkg::*;
(
  input  logic                 clk_pix,
  input  logic                 wr_en,
  input  logic [SRC_W-1:0]     wr_addr,
  input  logic [SPR_DATAW-1:0] wr_data,
  input  logic [SRC_W-1:0]     rd_addr,
  output logic [SPR_DATAW-1:0] rd_data
);

  logic [SPR_DATAW-1:0] mem [SPR_WIDTH];

  // Contents are fully rewritten each line before use, so no reset is needed.
  always_ff @(posedge clk_pix) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_linebuf.sv
// Sprite engine: fetches one sprite row into a line buffer during blanking and
// replays it with integer magnification and left/right clipping during active video.
module sprite_linebuf
  import twilight_pkg::*;
#(
  parameter int SX_OFFS = 3
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic                 line,
  input  logic [CORDW-1:0]     sx,
  input  logic [CORDW-1:0]     sy,
  input  logic [CORDW-1:0]     sprx,
  input  logic [CORDW-1:0]     spry,
  output logic                 rom_rd,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [SPR_DATAW-1:0] rom_data,
  output logic [SPR_DATAW-1:0] pix,
  output logic                 drawing,
  output logic                 busy
);

  localparam logic signed [CORDW:0] H_RES_S   = (CORDW+1)'(H_RES);
  localparam logic signed [CORDW:0] SX_OFFS_S = (CORDW+1)'(SX_OFFS);
  localparam logic signed [CORDW:0] SPR_W_S   = (CORDW+1)'(SPR_W_PIX);
  localparam logic signed [CORDW:0] SPR_H_S   = (CORDW+1)'(SPR_H_PIX);
  localparam logic [SUB_W-1:0]      SUB_MAX   = SUB_W'((1 << SPR_SCALE) - 1);
  localparam logic [SRC_W-1:0]      SRC_LAST  = SRC_W'(SPR_WIDTH - 1);

  spr_state_t state_reg, state_next;
  logic [CORDW-1:0]     xl_reg, xl_next;
  logic [ROW_W-1:0]     row_reg, row_next;
  logic [FCNT_W-1:0]    fcnt_reg, fcnt_next;
  logic [SRC_W-1:0]     src_reg, src_next;
  logic [SUB_W-1:0]     sub_reg, sub_next;
  logic [SPR_DATAW-1:0] pix_reg, pix_next;
  logic                 drawing_reg, drawing_next;

  // Signed coordinate arithmetic is done one bit wider so it cannot overflow.
  logic signed [CORDW:0] col_la, sx_ext, sy_ext, spry_ext, xl_ext, xl_end, dy;
  logic                  row_hit, hit_edge, hit_clip, start, emit;
  logic [OFF_W-1:0]      off;
  logic [SRC_W-1:0]      src0, cur_src;
  logic [SUB_W-1:0]      sub0, cur_sub;
  logic [SPR_DATAW-1:0]  rd_data;
  logic                  wr_en;
  logic [SRC_W-1:0]      wr_addr;

  assign sx_ext   = {sx[CORDW-1], sx};
  assign sy_ext   = {sy[CORDW-1], sy};
  assign spry_ext = {spry[CORDW-1], spry};
  assign xl_ext   = {xl_reg[CORDW-1], xl_reg};
  assign col_la   = sx_ext + SX_OFFS_S;
  assign xl_end   = xl_ext + SPR_W_S;
  assign dy       = sy_ext - spry_ext;
  assign row_hit  = !dy[CORDW] && (dy < SPR_H_S);

  // A sprite starting left of column 0 is entered part-way through at column 0.
  assign hit_edge = (col_la == xl_ext) && !xl_reg[CORDW-1] && (col_la < H_RES_S);
  assign hit_clip = (col_la == '0) && xl_reg[CORDW-1] && !xl_end[CORDW] && (xl_end != '0);
  assign start    = hit_edge || hit_clip;

  // Offset into the scaled sprite is below SPR_W_PIX whenever start fires, so low bits suffice.
  assign off     = col_la[OFF_W-1:0] - xl_reg[OFF_W-1:0];
  assign src0    = off[OFF_W-1 -: SRC_W];
  assign sub0    = off[SUB_W-1:0];
  assign cur_src = (state_reg == DRAW) ? src_reg : src0;
  assign cur_sub = (state_reg == DRAW) ? sub_reg : sub0;

  // ROM data for the read issued at count k arrives while the count is k+1.
  assign rom_rd   = (state_reg == FETCH) && !fcnt_reg[FCNT_W-1];
  assign rom_addr = rom_rd ? rom_index(row_reg, fcnt_reg[SRC_W-1:0]) : '0;
  assign wr_en    = (state_reg == FETCH) && (fcnt_reg != '0);
  assign wr_addr  = fcnt_reg[SRC_W-1:0] - SRC_W'(1);
  assign busy     = (state_reg == FETCH);

  spr_line_ram u_line_ram (
    .clk_pix (clk_pix),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (rom_data),
    .rd_addr (cur_src),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      xl_reg      <= '0;
      row_reg     <= '0;
      fcnt_reg    <= '0;
      src_reg     <= '0;
      sub_reg     <= '0;
      pix_reg     <= '0;
      drawing_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      xl_reg      <= xl_next;
      row_reg     <= row_next;
      fcnt_reg    <= fcnt_next;
      src_reg     <= src_next;
      sub_reg     <= sub_next;
      pix_reg     <= pix_next;
      drawing_reg <= drawing_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    xl_next      = xl_reg;
    row_next     = row_reg;
    fcnt_next    = fcnt_reg;
    src_next     = src_reg;
    sub_next     = sub_reg;
    pix_next     = '0;
    drawing_next = 1'b0;
    emit         = 1'b0;

    case (state_reg)
      IDLE: ;
      FETCH: begin
        fcnt_next = fcnt_reg + FCNT_W'(1);
        if (fcnt_reg == FCNT_W'(SPR_WIDTH)) state_next = WAIT;
      end
      WAIT: emit = start;
      DRAW: begin
        if (col_la >= H_RES_S) state_next = IDLE;
        else                   emit = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // The start cycle already emits its pixel so the output lines up with col_la.
    if (emit) begin
      pix_next     = rd_data;
      drawing_next = 1'b1;
      if (cur_sub == SUB_MAX) begin
        sub_next = '0;
        if (cur_src == SRC_LAST) begin
          state_next = IDLE;
        end else begin
          src_next   = cur_src + SRC_W'(1);
          state_next = DRAW;
        end
      end else begin
        sub_next   = cur_sub + SUB_W'(1);
        src_next   = cur_src;
        state_next = DRAW;
      end
    end

    if (line) begin
      xl_next      = sprx;
      fcnt_next    = '0;
      pix_next     = '0;
      drawing_next = 1'b0;
      if (row_hit) begin
        row_next   = dy[SPR_SCALE +: ROW_W];
        state_next = FETCH;
      end else begin
        state_next = IDLE;
      end
    end
  end

  assign pix     = pix_reg;
  assign drawing = drawing_reg;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Drives whole video lines and compares every output column against a
// column-by-column geometric model of the magnified, clipped sprite.
module tb_sprite_linebuf;
  import twilight_pkg::*;

  localparam int SX_OFFS  = 3;
  localparam int BLANK    = 160;
  localparam int LINE_LEN = BLANK + H_RES;
  localparam int ROM_SIZE = SPR_WIDTH * SPR_HEIGHT;

  logic                 clk_pix = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 line    = 1'b0;
  logic [CORDW-1:0]     sx      = '0;
  logic [CORDW-1:0]     sy      = '0;
  logic [CORDW-1:0]     sprx    = '0;
  logic [CORDW-1:0]     spry    = '0;
  logic                 rom_rd;
  logic [ROM_AW-1:0]    rom_addr;
  logic [SPR_DATAW-1:0] rom_data = '0;
  logic [SPR_DATAW-1:0] pix;
  logic                 drawing;
  logic                 busy;

  logic [SPR_DATAW-1:0] rom_mem [ROM_SIZE];
  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk_pix = ~clk_pix;

  // Synchronous sprite ROM: data valid the cycle after the read strobe.
  always @(posedge clk_pix) begin
    if (rom_rd) rom_data <= rom_mem[rom_addr];
  end

  sprite_linebuf #(.SX_OFFS(SX_OFFS)) dut (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .line     (line),
    .sx       (sx),
    .sy       (sy),
    .sprx     (sprx),
    .spry     (spry),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix      (pix),
    .drawing  (drawing),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Runs ncyc cycles of one line (line pulse at cycle 0); chg scrambles sprx/spry after the pulse.
  task automatic run_line(input int px, input int py, input int yy, input bit chg,
                          input int ncyc, output int ndraw);
    int  dy, row, col, nrd, nbusy, exp_val;
    bit  act, vis;
    dy    = yy - py;
    act   = (dy >= 0) && (dy < SPR_H_PIX);
    row   = act ? dy / (1 << SPR_SCALE) : 0;
    ndraw = 0;
    nrd   = 0;
    nbusy = 0;
    for (int i = 0; i < ncyc; i++) begin
      line = (i == 0);
      sx   = CORDW'(i - BLANK);
      sy   = CORDW'(yy);
      sprx = CORDW'((chg && i > 0) ? px + 37 : px);
      spry = CORDW'((chg && i > 0) ? py - 2 : py);
      @(posedge clk_pix);
      #1;
      col = i - BLANK + SX_OFFS;
      vis = act && col >= 0 && col < H_RES && col >= px && col < px + SPR_W_PIX;
      exp_val = vis ? ((1 << SPR_DATAW) +
                       int'(rom_mem[row * SPR_WIDTH + (col - px) / (1 << SPR_SCALE)])) : 0;
      check_eq($sformatf("pixel col %0d", col), 32'({drawing, pix}), 32'(exp_val));
      if (drawing) ndraw++;
      if (busy) nbusy++;
      if (rom_rd) begin
        check_eq("rom_addr", 32'(rom_addr), 32'(row * SPR_WIDTH + nrd));
        nrd++;
      end
    end
    line = 1'b0;
    if (ncyc == LINE_LEN) begin
      check_eq("rom_rd count", 32'(nrd), act ? 32'(SPR_WIDTH) : 32'd0);
      check_eq("busy cycles", 32'(nbusy), act ? 32'(SPR_WIDTH + 1) : 32'd0);
    end
    $display("line sprx=%0d spry=%0d sy=%0d chg=%0d drawn=%0d reads=%0d", px, py, yy, chg, ndraw, nrd);
  endtask

  initial begin
    int nd, px, py, yy;
    for (int a = 0; a < ROM_SIZE; a++) rom_mem[a] = SPR_DATAW'(a % SPR_WIDTH);

    repeat (3) @(posedge clk_pix);
    #1;
    check_eq("reset pix", 32'(pix), 32'd0);
    check_eq("reset drawing", 32'(drawing), 32'd0);
    check_eq("reset rom_rd", 32'(rom_rd), 32'd0);
    check_eq("reset rom_addr", 32'(rom_addr), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    run_line(100, 240, 240, 1'b0, LINE_LEN, nd);  check_eq("draw count x100", 32'(nd), 32'd128);
    run_line(100, 240, 239, 1'b0, LINE_LEN, nd);  check_eq("draw count above", 32'(nd), 32'd0);
    run_line(100, 240, 320, 1'b0, LINE_LEN, nd);  check_eq("draw count below", 32'(nd), 32'd0);
    run_line(100, 240, 245, 1'b0, LINE_LEN, nd);  check_eq("draw count row1", 32'(nd), 32'd128);
    run_line(-10, 240, 240, 1'b0, LINE_LEN, nd);  check_eq("draw count left clip", 32'(nd), 32'd118);
    run_line(600, 240, 240, 1'b0, LINE_LEN, nd);  check_eq("draw count right clip", 32'(nd), 32'd40);
    run_line(640, 240, 240, 1'b0, LINE_LEN, nd);  check_eq("draw count offscreen", 32'(nd), 32'd0);
    run_line(100, 240, 250, 1'b1, LINE_LEN, nd);  check_eq("draw count mid-change", 32'(nd), 32'd128);

    for (int a = 0; a < ROM_SIZE; a++) rom_mem[a] = SPR_DATAW'($urandom);
    for (int n = 0; n < 22; n++) begin
      px = int'($urandom_range(0, 1000)) - 250;
      py = int'($urandom_range(0, 500)) - 20;
      yy = py + int'($urandom_range(0, 100)) - 10;
      run_line(px, py, yy, 1'($urandom), LINE_LEN, nd);
    end

    // Reset mid-draw: outputs clear asynchronously, nothing resumes after release.
    run_line(100, 240, 240, 1'b0, BLANK + 150, nd);
    rst_n = 1'b0;
    #1;
    check_eq("async reset drawing", 32'(drawing), 32'd0);
    check_eq("async reset pix", 32'(pix), 32'd0);
    check_eq("async reset busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk_pix);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      sx = CORDW'(300 + j);
      @(posedge clk_pix);
      #1;
      check_eq("post-reset idle", 32'({drawing, pix}), 32'd0);
    end
    run_line(100, 240, 240, 1'b0, LINE_LEN, nd);  check_eq("draw count after reset", 32'(nd), 32'd128);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
